mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor's data-memory port, alongside `dmem`. It decodes the core's store and load bus and accepts byte writes into a transmit FIFO. It serialises queued bytes as 8N1 frames on `tx` and returns status and divisor values on reads. The top level uses `hit` to choose between this block's `rd` and `dmem`'s `rd`.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/mmio_uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;
  localparam int unsigned ST_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // A zero divisor would stall the bit counter, so it is stored as 1.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full is derived from the pointers
// alone, so a push is refused when full regardless of any same-cycle pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/DIVISOR registers,
// transmit FIFO and the serialising FSM.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    offset;
  logic          wr_txdata, wr_status, wr_div;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_w;
  logic          unused_bits;

  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  assign offset      = addr[3:0];
  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata   = we && hit && (offset == UART_TXDATA);
  assign wr_status   = we && hit && (offset == UART_STATUS);
  assign wr_div      = we && hit && (offset == UART_DIV);
  assign fifo_push   = wr_txdata && !fifo_full;
  assign fifo_pop    = (state_q == IDLE) && !fifo_empty;
  assign tx          = tx_q;
  assign unused_bits = ^wd[31:16];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (wd[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    status_w                               = '0;
    status_w[ST_FULL]                      = fifo_full;
    status_w[ST_EMPTY]                     = fifo_empty;
    status_w[ST_BUSY]                      = (state_q != IDLE);
    status_w[ST_OVF]                       = ovf_q;
    status_w[ST_CNT_LSB +: ST_CNT_W]       = ST_CNT_W'(fifo_count);
    rd = '0;
    if (hit) begin
      case (offset)
        UART_STATUS: rd = status_w;
        UART_DIV:    rd = {16'd0, div_q};
        default:     rd = '0;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full)         ovf_d = 1'b1;
    else if (wr_status && wd[ST_OVF])   ovf_d = 1'b0;
    div_d = div_q;
    if (wr_div) div_d = div_sanitize(wd[15:0]);
  end

  // Every bit boundary reloads the period counter from the live divisor, so a
  // divisor write lands on the next bit; tx_d is the level of the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d = fifo_dout;
          cnt_d   = div_q - 16'd1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          cnt_d   = div_q - 16'd1;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      div_q   <= DIV_RESET;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
